// File: rtl/ps2_pkg.sv
// Purpose : shared set-2 scancode constants, decoder state encoding and key event word.
// Latency : n/a (types, constants and pure functions only).
// Backpressure: n/a.
//
// Contents: prefix/control byte values, modifier scancodes, dec_state_t, key_evt_t
// (10-bit {ext, brk, code}), kbd_status codes, idle-byte classifier, fake-shift test.
package ps2_pkg;

   localparam logic [7:0] PREFIX_EXT   = 8'hE0;
   localparam logic [7:0] PREFIX_BRK   = 8'hF0;
   localparam logic [7:0] PREFIX_PAUSE = 8'hE1;
   localparam logic [7:0] BAT_OK       = 8'hAA;
   localparam logic [7:0] KBD_ACK      = 8'hFA;
   localparam logic [7:0] KBD_ECHO     = 8'hEE;
   localparam logic [7:0] KBD_RESEND   = 8'hFE;
   localparam logic [7:0] KBD_ERR_FC   = 8'hFC;
   localparam logic [7:0] KBD_ERR_FD   = 8'hFD;
   localparam logic [7:0] KBD_ERR_00   = 8'h00;
   localparam logic [7:0] KBD_ERR_FF   = 8'hFF;

   localparam logic [7:0] SC_LSHIFT = 8'h12;
   localparam logic [7:0] SC_RSHIFT = 8'h59;
   localparam logic [7:0] SC_CTRL   = 8'h14;
   localparam logic [7:0] SC_ALT    = 8'h11;
   localparam logic [7:0] SC_CAPS   = 8'h58;
   localparam logic [7:0] SC_PAUSE  = 8'h77;

   // Bytes still to swallow after E1: the Pause make/break sequence is E1 + 7 bytes.
   localparam logic [2:0] PAUSE_TAIL = 3'd7;

   localparam int EVT_W = 10;

   typedef struct packed {
      logic       ext;
      logic       brk;
      logic [7:0] code;
   } key_evt_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_GOT_E0,
      ST_GOT_F0,
      ST_GOT_E0F0,
      ST_PAUSE_SKIP
   } dec_state_t;

   typedef enum logic [1:0] {
      KBD_NONE   = 2'b00,
      KBD_BAT_OK = 2'b01,
      KBD_ERROR  = 2'b10,
      KBD_RSVD   = 2'b11
   } kbd_status_t;

   typedef enum logic [2:0] {
      CLS_EXT,
      CLS_BRK,
      CLS_PAUSE,
      CLS_BAT,
      CLS_ERR,
      CLS_DISCARD,
      CLS_KEY
   } byte_cls_t;

   // What a byte means when no prefix is pending.
   function automatic byte_cls_t classify_idle(input logic [7:0] b);
      byte_cls_t cls;
      case (b)
         PREFIX_EXT:                                      cls = CLS_EXT;
         PREFIX_BRK:                                      cls = CLS_BRK;
         PREFIX_PAUSE:                                    cls = CLS_PAUSE;
         BAT_OK:                                          cls = CLS_BAT;
         KBD_ERR_FC, KBD_ERR_FD, KBD_ERR_00, KBD_ERR_FF:  cls = CLS_ERR;
         KBD_ACK, KBD_ECHO, KBD_RESEND:                   cls = CLS_DISCARD;
         default:                                         cls = CLS_KEY;
      endcase
      return cls;
   endfunction

   // E0 12 / E0 59 are shift-state fixups the keyboard injects around
   // navigation keys; they are not real key events.
   function automatic logic is_fake_shift(input logic [7:0] b);
      return (b == SC_LSHIFT) || (b == SC_RSHIFT);
   endfunction

endpackage

// File: rtl/ps2_scancode_decoder_if.sv
// Purpose : scan byte input and key event output bundle of the scancode decoder.
// Latency : n/a (wiring only).
// Backpressure: key_ready pops the head event; scan side has no backpressure.
//
// Ports: scan_valid/scan_code from the receiver; key_valid/key_ready handshake with
// key_code/key_extended/key_release head event. slave = decoder, master = environment.
interface ps2_scancode_decoder_if;

   logic       scan_valid;
   logic [7:0] scan_code;
   logic       key_valid;
   logic       key_ready;
   logic [7:0] key_code;
   logic       key_extended;
   logic       key_release;

   modport master (
      output scan_valid, scan_code, key_ready,
      input  key_valid, key_code, key_extended, key_release
   );

   modport slave (
      input  scan_valid, scan_code, key_ready,
      output key_valid, key_code, key_extended, key_release
   );

endinterface

// File: rtl/ps2_event_fifo.sv
// Purpose : synchronous show-ahead FIFO for decoded key events.
// Latency : write visible at the head one cycle after the push edge when empty.
// Backpressure: push refused when full unless a pop happens the same cycle.
//
// Ports: clk32, rst_n (async active-low), wr_en/wr_dat push, rd_en pop (ignored
// when empty), rd_dat head word (zero when empty), full, empty.
module ps2_event_fifo #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 10
) (
   input  logic             clk32,
   input  logic             rst_n,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_dat,
   input  logic             rd_en,
   output logic [WIDTH-1:0] rd_dat,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   // One extra wrap bit distinguishes full from empty when the indices match.
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic [WIDTH-1:0] mem [DEPTH];
   logic             do_wr;
   logic             do_rd;

   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

   assign do_rd = rd_en & ~empty;
   // A pop in the same cycle frees the slot the push needs.
   assign do_wr = wr_en & (~full | do_rd);

   // Head is forced to zero when empty so outputs are clean out of reset.
   assign rd_dat = empty ? '0 : mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk32 or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_wr) wr_ptr <= wr_ptr + 1'b1;
         if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk32) begin
      if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_dat;
   end

endmodule

// File: rtl/ps2_scancode_decoder.sv
// Purpose : folds PS/2 set-2 prefix sequences into {extended, release, code} key events.
// Latency : event written at the edge of the final byte; head visible next cycle if empty.
// Backpressure: events queue in a FIFO popped by key_ready; full FIFO drops and sets overflow.
//
// Ports: clk32, rst_n (async active-low); bus (slave) carries scan bytes in and the
// key event handshake out; mod_shift/mod_ctrl/mod_alt/caps_lock live modifier state;
// kbd_status last BAT/error report; overflow sticky drop flag cleared by ovf_clr.
module ps2_scancode_decoder
   import ps2_pkg::*;
#(
   parameter int FIFO_DEPTH     = 8,
   parameter int PREFIX_TIMEOUT = 320000
) (
   input  logic                   clk32,
   input  logic                   rst_n,
   ps2_scancode_decoder_if.slave  bus,
   output logic                   mod_shift,
   output logic                   mod_ctrl,
   output logic                   mod_alt,
   output logic                   caps_lock,
   output logic [1:0]             kbd_status,
   output logic                   overflow,
   input  logic                   ovf_clr
);

   localparam int             TW       = $clog2(PREFIX_TIMEOUT + 1);
   localparam logic [TW-1:0]  TMO_LOAD = TW'(PREFIX_TIMEOUT);

   dec_state_t        state;
   logic [2:0]        pause_cnt;
   logic [TW-1:0]     tmo;
   logic              caps_held;

   logic              evt_push;
   key_evt_t          evt;
   key_evt_t          head;
   logic [EVT_W-1:0]  fifo_rd_dat;
   logic              fifo_full;
   logic              fifo_empty;
   logic              pop;
   logic              drop;

   // ------------------------------------------------------------------
   // Event decode: combinational so the event is written on the same edge
   // that accepts the byte completing it.
   // ------------------------------------------------------------------
   always_comb begin
      evt_push = 1'b0;
      evt      = '{ext: 1'b0, brk: 1'b0, code: bus.scan_code};
      if (bus.scan_valid) begin
         case (state)
            ST_IDLE: begin
               evt_push = (classify_idle(bus.scan_code) == CLS_KEY);
            end
            ST_GOT_E0: begin
               evt.ext  = 1'b1;
               evt_push = (bus.scan_code != PREFIX_BRK) && !is_fake_shift(bus.scan_code);
            end
            ST_GOT_F0: begin
               evt.brk  = 1'b1;
               evt_push = 1'b1;
            end
            ST_GOT_E0F0: begin
               evt.ext  = 1'b1;
               evt.brk  = 1'b1;
               evt_push = !is_fake_shift(bus.scan_code);
            end
            ST_PAUSE_SKIP: begin
               // The whole Pause sequence collapses into one extended 77 make.
               evt      = '{ext: 1'b1, brk: 1'b0, code: SC_PAUSE};
               evt_push = (pause_cnt == 3'd1);
            end
            default: evt_push = 1'b0;
         endcase
      end
   end

   assign pop  = ~fifo_empty & bus.key_ready;
   assign drop = evt_push & fifo_full & ~pop;

   // ------------------------------------------------------------------
   // Prefix FSM, timeout, modifiers and status.
   // ------------------------------------------------------------------
   always_ff @(posedge clk32 or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         pause_cnt  <= '0;
         tmo        <= '0;
         caps_held  <= 1'b0;
         mod_shift  <= 1'b0;
         mod_ctrl   <= 1'b0;
         mod_alt    <= 1'b0;
         caps_lock  <= 1'b0;
         kbd_status <= KBD_NONE;
         overflow   <= 1'b0;
      end else begin
         if (drop)         overflow <= 1'b1;
         else if (ovf_clr) overflow <= 1'b0;

         // Modifiers follow the decoded event even if the FIFO drops it.
         if (evt_push) begin
            case (evt.code)
               SC_LSHIFT, SC_RSHIFT: mod_shift <= ~evt.brk;
               SC_CTRL:              mod_ctrl  <= ~evt.brk;
               SC_ALT:               mod_alt   <= ~evt.brk;
               SC_CAPS: begin
                  // Only the first make of a press toggles; typematic repeats are ignored.
                  if (!evt.brk && !caps_held) caps_lock <= ~caps_lock;
                  caps_held <= ~evt.brk;
               end
               default: ;
            endcase
         end

         if (bus.scan_valid) begin
            tmo <= TMO_LOAD;
            case (state)
               ST_IDLE: begin
                  case (classify_idle(bus.scan_code))
                     CLS_EXT:   state <= ST_GOT_E0;
                     CLS_BRK:   state <= ST_GOT_F0;
                     CLS_PAUSE: begin
                        state     <= ST_PAUSE_SKIP;
                        pause_cnt <= PAUSE_TAIL;
                     end
                     CLS_BAT:   kbd_status <= KBD_BAT_OK;
                     CLS_ERR:   kbd_status <= KBD_ERROR;
                     default:   ;
                  endcase
               end
               ST_GOT_E0: begin
                  state <= (bus.scan_code == PREFIX_BRK) ? ST_GOT_E0F0 : ST_IDLE;
               end
               ST_PAUSE_SKIP: begin
                  pause_cnt <= pause_cnt - 3'd1;
                  if (pause_cnt == 3'd1) state <= ST_IDLE;
               end
               default: state <= ST_IDLE;
            endcase
         end else if (state != ST_IDLE) begin
            // A stalled prefix is abandoned silently once the budget runs out.
            if (tmo == '0) begin
               state     <= ST_IDLE;
               pause_cnt <= '0;
            end else begin
               tmo <= tmo - TW'(1);
            end
         end
      end
   end

   // ------------------------------------------------------------------
   // Event queue
   // ------------------------------------------------------------------
   ps2_event_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (EVT_W)
   ) u_fifo (
      .clk32  (clk32),
      .rst_n  (rst_n),
      .wr_en  (evt_push),
      .wr_dat (evt),
      .rd_en  (bus.key_ready),
      .rd_dat (fifo_rd_dat),
      .full   (fifo_full),
      .empty  (fifo_empty)
   );

   assign head             = key_evt_t'(fifo_rd_dat);
   assign bus.key_valid    = ~fifo_empty;
   assign bus.key_code     = head.code;
   assign bus.key_extended = head.ext;
   assign bus.key_release  = head.brk;

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Purpose : self-checking bench for ps2_scancode_decoder against a byte-level reference model.
// Latency : n/a.
// Backpressure: bench drives key_ready explicitly per scenario.
module tb_ps2_scancode_decoder;

   localparam int TMO   = 200;
   localparam int DEPTH = 8;

   logic       clk32;
   logic       rst_n;
   logic       ovf_clr;
   logic       mod_shift, mod_ctrl, mod_alt, caps_lock, overflow;
   logic [1:0] kbd_status;

   ps2_scancode_decoder_if kif ();

   ps2_scancode_decoder #(
      .FIFO_DEPTH     (DEPTH),
      .PREFIX_TIMEOUT (TMO)
   ) dut (
      .clk32      (clk32),
      .rst_n      (rst_n),
      .bus        (kif),
      .mod_shift  (mod_shift),
      .mod_ctrl   (mod_ctrl),
      .mod_alt    (mod_alt),
      .caps_lock  (caps_lock),
      .kbd_status (kbd_status),
      .overflow   (overflow),
      .ovf_clr    (ovf_clr)
   );

   initial clk32 = 1'b0;
   always #5 clk32 = ~clk32;

   int checks = 0;
   int errors = 0;

   // ---------------- reference model ----------------
   logic [9:0] exp_q [$];
   logic       m_ext, m_brk, m_shift, m_ctrl, m_alt, m_caps, m_held, m_ovf, m_drop;
   int         m_pause;
   logic [1:0] m_stat;

   task automatic model_reset();
      exp_q.delete();
      m_ext = 0; m_brk = 0; m_pause = 0;
      m_shift = 0; m_ctrl = 0; m_alt = 0; m_caps = 0; m_held = 0;
      m_ovf = 0; m_stat = 2'b00; m_drop = 0;
   endtask

   task automatic model_emit(input logic e, input logic r, input logic [7:0] c);
      if (c == 8'h12 || c == 8'h59) m_shift = !r;
      if (c == 8'h14) m_ctrl = !r;
      if (c == 8'h11) m_alt = !r;
      if (c == 8'h58) begin
         if (!r && !m_held) m_caps = !m_caps;
         m_held = !r;
      end
      if (exp_q.size() >= DEPTH) begin
         m_ovf  = 1;
         m_drop = 1;
      end else begin
         exp_q.push_back({e, r, c});
      end
   endtask

   task automatic model_byte(input logic [7:0] b);
      if (m_pause > 0) begin
         m_pause--;
         if (m_pause == 0) model_emit(1'b1, 1'b0, 8'h77);
      end else if (!m_ext && !m_brk) begin
         case (b)
            8'hE0: m_ext = 1;
            8'hF0: m_brk = 1;
            8'hE1: m_pause = 7;
            8'hAA: m_stat = 2'b01;
            8'hFC, 8'hFD, 8'h00, 8'hFF: m_stat = 2'b10;
            8'hFA, 8'hEE, 8'hFE: ;
            default: model_emit(1'b0, 1'b0, b);
         endcase
      end else if (m_ext && !m_brk && b == 8'hF0) begin
         m_brk = 1;
      end else begin
         if (!(m_ext && (b == 8'h12 || b == 8'h59))) model_emit(m_ext, m_brk, b);
         m_ext = 0;
         m_brk = 0;
      end
   endtask

   // ---------------- stimulus primitives ----------------
   task automatic cyc(input int n);
      repeat (n) @(negedge clk32);
   endtask

   // An idle gap longer than the timeout abandons any pending prefix.
   task automatic idle(input int n);
      cyc(n);
      if (n > TMO) begin
         m_ext = 0; m_brk = 0; m_pause = 0;
      end
   endtask

   task automatic send(input logic [7:0] b);
      kif.scan_valid = 1'b1;
      kif.scan_code  = b;
      m_drop = 0;
      model_byte(b);
      if (ovf_clr && !m_drop) m_ovf = 0;
      @(negedge clk32);
      kif.scan_valid = 1'b0;
      kif.scan_code  = 8'h00;
   endtask

   task automatic compare_status(input string tag);
      checks++;
      if ({mod_shift, mod_ctrl, mod_alt, caps_lock, kbd_status, overflow} !==
          {m_shift, m_ctrl, m_alt, m_caps, m_stat, m_ovf}) begin
         errors++;
         $display("FAIL %s status {shift,ctrl,alt,caps,stat,ovf}: got %b expected %b", tag,
                  {mod_shift, mod_ctrl, mod_alt, caps_lock, kbd_status, overflow},
                  {m_shift, m_ctrl, m_alt, m_caps, m_stat, m_ovf});
      end
   endtask

   task automatic drain_fifo(input string tag);
      logic [9:0] ev;
      while (exp_q.size() > 0) begin
         checks++;
         if (kif.key_valid !== 1'b1 ||
             {kif.key_extended, kif.key_release, kif.key_code} !== exp_q[0]) begin
            errors++;
            $display("FAIL %s event: got vld=%b {ext,rel,code}=%b_%b_%h expected vld=1 %b_%b_%h",
                     tag, kif.key_valid, kif.key_extended, kif.key_release, kif.key_code,
                     exp_q[0][9], exp_q[0][8], exp_q[0][7:0]);
         end
         kif.key_ready = 1'b1;
         @(negedge clk32);
         kif.key_ready = 1'b0;
         ev = exp_q.pop_front();
      end
      checks++;
      if (kif.key_valid !== 1'b0) begin
         errors++;
         $display("FAIL %s empty: key_valid got %b expected 0", tag, kif.key_valid);
      end
   endtask

   function automatic logic [7:0] rand_byte();
      int unsigned r;
      r = $urandom_range(0, 19);
      case (r)
         0, 1:    return 8'hE0;
         2, 3:    return 8'hF0;
         4:       return 8'hE1;
         5:       return 8'hAA;
         6:       return 8'hFC;
         7:       return 8'hFA;
         8:       return 8'h12;
         9:       return 8'h59;
         10:      return 8'h14;
         11:      return 8'h11;
         12:      return 8'h58;
         default: return 8'($urandom_range(1, 127));
      endcase
   endfunction

   // ---------------- scenarios ----------------
   task automatic test_reset();
      cyc(3);
      checks++;
      if ({kif.key_valid, kif.key_code, kif.key_extended, kif.key_release} !== 11'd0) begin
         errors++;
         $display("FAIL reset key outputs: got %b expected 0",
                  {kif.key_valid, kif.key_code, kif.key_extended, kif.key_release});
      end
      compare_status("reset");
      rst_n = 1'b1;
      cyc(2);
   endtask

   task automatic test_basic();
      kif.scan_valid = 1'b1;
      kif.scan_code  = 8'h1C;
      model_byte(8'h1C);
      checks++;
      if (kif.key_valid !== 1'b0) begin
         errors++;
         $display("FAIL basic strobe cycle: key_valid got %b expected 0", kif.key_valid);
      end
      @(negedge clk32);
      kif.scan_valid = 1'b0;
      checks++;
      if (kif.key_valid !== 1'b1) begin
         errors++;
         $display("FAIL basic latency: key_valid got %b expected 1", kif.key_valid);
      end
      send(8'hF0);
      send(8'h1C);
      drain_fifo("basic");
   endtask

   task automatic test_extended();
      send(8'hE0); send(8'hF0); send(8'h75);
      send(8'hE0); send(8'h12); send(8'hE0); send(8'h7C);
      compare_status("prtsc");
      drain_fifo("extended");
   endtask

   task automatic test_pause();
      logic [7:0] seq [8];
      seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
      foreach (seq[i]) send(seq[i]);
      send(8'h1C);
      drain_fifo("pause");
   endtask

   task automatic test_timeout();
      // Byte arriving on the last cycle of the budget still completes the prefix.
      send(8'hE0); idle(TMO);     send(8'h1C);
      send(8'hE0); idle(TMO + 1); send(8'h1C);
      send(8'hF0); idle($urandom_range(1, TMO - 1)); send(8'h2A);
      send(8'hE1); send(8'h14); idle(TMO + 3); send(8'h1C);
      drain_fifo("timeout");
   endtask

   task automatic test_overflow();
      logic [7:0] b;
      logic [9:0] ev;
      for (int i = 0; i < DEPTH + 1; i++) send(8'($urandom_range(1, 127)));
      compare_status("ovf set");
      ovf_clr = 1'b1; @(negedge clk32); ovf_clr = 1'b0; m_ovf = 0;
      compare_status("ovf clr");
      // Set wins over clear in the same cycle.
      ovf_clr = 1'b1; send(8'h3B); ovf_clr = 1'b0;
      compare_status("ovf prio");
      ovf_clr = 1'b1; @(negedge clk32); ovf_clr = 1'b0; m_ovf = 0;
      // Full with simultaneous push and pop: both happen, nothing lost.
      b = 8'($urandom_range(1, 127));
      checks++;
      if ({kif.key_extended, kif.key_release, kif.key_code} !== exp_q[0]) begin
         errors++;
         $display("FAIL full head: got %h expected %h",
                  {kif.key_extended, kif.key_release, kif.key_code}, exp_q[0]);
      end
      kif.key_ready = 1'b1;
      ev = exp_q.pop_front();
      send(b);
      kif.key_ready = 1'b0;
      compare_status("push+pop full");
      drain_fifo("overflow");
   endtask

   task automatic test_modifiers();
      send(8'h58); send(8'h58); send(8'hF0); send(8'h58);
      compare_status("caps on");
      send(8'h58);
      compare_status("caps held");
      send(8'hF0); send(8'h58); send(8'h58);
      compare_status("caps off");
      drain_fifo("mods1");
      send(8'h12);            compare_status("shift make");
      send(8'hF0); send(8'h12); compare_status("shift break");
      send(8'hE0); send(8'h14); compare_status("rctrl make");
      send(8'h11);            compare_status("lalt make");
      drain_fifo("mods2");
      send(8'hE0); send(8'hF0); send(8'h14); compare_status("rctrl break");
      send(8'hAA);            compare_status("bat ok");
      send(8'hFA);            compare_status("ack discard");
      send(8'hFD);            compare_status("kbd error");
      drain_fifo("mods3");
   endtask

   task automatic test_random();
      for (int blk = 0; blk < 12; blk++) begin
         for (int i = 0; i < 6; i++) begin
            send(rand_byte());
            compare_status("random");
         end
         drain_fifo("random");
      end
      idle(TMO + 2);
   endtask

   task automatic test_reset_mid();
      send(8'h12); send(8'h1C); send(8'hE0);
      rst_n = 1'b0;
      #1;
      model_reset();
      checks++;
      if ({kif.key_valid, kif.key_code, kif.key_extended, kif.key_release} !== 11'd0) begin
         errors++;
         $display("FAIL reset mid key outputs: got %b expected 0",
                  {kif.key_valid, kif.key_code, kif.key_extended, kif.key_release});
      end
      compare_status("reset mid");
      cyc(2);
      rst_n = 1'b1;
      cyc(1);
      send(8'h1C);
      drain_fifo("after reset");
   endtask

   initial begin
      rst_n          = 1'b0;
      ovf_clr        = 1'b0;
      kif.scan_valid = 1'b0;
      kif.scan_code  = 8'h00;
      kif.key_ready  = 1'b0;
      model_reset();
      test_reset();
      test_basic();
      test_extended();
      test_pause();
      test_timeout();
      test_overflow();
      test_modifiers();
      test_random();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
